// File: rtl/cp0_intc_if.sv
// Bus bundle between the CP0 core side and cp0_intc: register read/write
// ports, raw interrupt lines, exception handshake and the registered request.
interface cp0_intc_if #(
    parameter int NIRQ = 6
);
    logic [NIRQ-1:0] irq_in;
    logic            cop0write;
    logic [4:0]      cp0_writeaddress;
    logic [4:0]      cp0_readaddress;
    logic [31:0]     writecop0;
    logic [31:0]     cop0readdata;
    logic            irq_ack;
    logic            eret;
    logic            irq_req;
    logic [4:0]      irq_id;

    modport master (
        output irq_in, cop0write, cp0_writeaddress, cp0_readaddress, writecop0, irq_ack, eret,
        input  cop0readdata, irq_req, irq_id
    );

    modport slave (
        input  irq_in, cop0write, cp0_writeaddress, cp0_readaddress, writecop0, irq_ack, eret,
        output cop0readdata, irq_req, irq_id
    );
endinterface

// File: rtl/cp0_intc.sv
// CP0 interrupt and timer controller: per-source enable, edge/level external
// lines, Count/Compare timers, nested in-service tracking, highest index wins.
module cp0_intc #(
    parameter int NIRQ    = 6,
    parameter int NTIMERS = 2
) (
    input  logic       clk,
    input  logic       reset,
    cp0_intc_if.slave  bus
);
    localparam int NSRC = NIRQ + NTIMERS;
    localparam logic [NSRC-1:0] ONE = {{(NSRC-1){1'b0}}, 1'b1};

    function automatic logic [4:0] f_top(input logic [NSRC-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < NSRC; i++) begin
            idx = v[i] ? 5'(i) : idx;
        end
        return idx;
    endfunction

    logic [NIRQ-1:0]    r_sync1, r_sync2, r_dly, r_mode, r_ip_edge;
    logic [NSRC-1:0]    r_ie, r_isr;
    logic               r_gie;
    logic [NTIMERS-1:0] r_ip_tmr;
    logic [31:0]        r_count   [NTIMERS];
    logic [31:0]        r_compare [NTIMERS];
    logic [1:0]         r_tctl    [NTIMERS];
    logic               r_irq_req;
    logic [4:0]         r_irq_id;

    logic [NIRQ-1:0]    w_ext_pend, w_ext_clr, w_ip_edge_next;
    logic [NSRC-1:0]    w_pend, w_cand, w_ack_vec, w_isr_eret, w_isr_next;
    logic [4:0]         w_top, w_cur;
    logic               w_req, w_ack, w_wr_ip;
    logic [NTIMERS-1:0] w_hit, w_wr_cnt, w_wr_cmp, w_wr_tctl, w_ip_tmr_next;
    logic [31:0]        w_tmr_rd, w_rdata;

    // Pending view, arbitration and the ack/eret effect on ISR and edge pending.
    always_comb begin
        w_wr_ip        = bus.cop0write & (bus.cp0_writeaddress == 5'h01);
        w_ack          = bus.irq_ack & r_irq_req;
        w_ack_vec      = w_ack ? (ONE << r_irq_id) : {NSRC{1'b0}};
        w_ext_pend     = (r_mode & r_ip_edge) | (~r_mode & r_sync2);
        w_pend         = {r_ip_tmr, w_ext_pend};
        w_cand         = w_pend & r_ie;
        w_top          = f_top(w_cand);
        w_cur          = f_top(r_isr);
        w_req          = r_gie & (|w_cand) & ((r_isr == {NSRC{1'b0}}) | (w_top > w_cur));
        w_ext_clr      = (w_wr_ip ? bus.writecop0[NIRQ-1:0] : {NIRQ{1'b0}}) | w_ack_vec[NIRQ-1:0];
        // A fresh edge beats any clear arriving in the same cycle.
        w_ip_edge_next = r_mode & ((r_sync2 & ~r_dly) | (r_ip_edge & ~w_ext_clr));
        if (bus.eret && (r_isr != {NSRC{1'b0}})) begin
            w_isr_eret = r_isr & ~(ONE << w_cur);
        end else begin
            w_isr_eret = r_isr;
        end
        w_isr_next     = w_isr_eret | w_ack_vec;
    end

    // Timer hit detection, register-write decode and timer pending next state.
    always_comb begin
        for (int t = 0; t < NTIMERS; t++) begin
            w_hit[t]     = r_tctl[t][0] & (r_count[t] == r_compare[t]);
            w_wr_cnt[t]  = bus.cop0write & (bus.cp0_writeaddress == 5'(8 + 2 * t));
            w_wr_cmp[t]  = bus.cop0write & (bus.cp0_writeaddress == 5'(9 + 2 * t));
            w_wr_tctl[t] = bus.cop0write & (bus.cp0_writeaddress == 5'(16 + t));
            if (w_wr_cmp[t]) begin
                w_ip_tmr_next[t] = 1'b0;
            end else if (w_hit[t]) begin
                w_ip_tmr_next[t] = 1'b1;
            end else if (w_wr_ip && bus.writecop0[NIRQ + t]) begin
                w_ip_tmr_next[t] = 1'b0;
            end else begin
                w_ip_tmr_next[t] = r_ip_tmr[t];
            end
        end
    end

    // Combinational register read mux.
    always_comb begin
        w_tmr_rd = 32'd0;
        for (int t = 0; t < NTIMERS; t++) begin
            w_tmr_rd = w_tmr_rd
                     | ((bus.cp0_readaddress == 5'(8 + 2 * t)) ? r_count[t]   : 32'd0)
                     | ((bus.cp0_readaddress == 5'(9 + 2 * t)) ? r_compare[t] : 32'd0)
                     | ((bus.cp0_readaddress == 5'(16 + t))    ? {30'd0, r_tctl[t]} : 32'd0);
        end
        case (bus.cp0_readaddress)
            5'h00:   w_rdata = 32'(r_ie);
            5'h01:   w_rdata = 32'(w_pend);
            5'h02:   w_rdata = 32'(r_mode);
            5'h03:   w_rdata = {31'd0, r_gie};
            5'h04:   w_rdata = 32'(r_isr);
            5'h05:   w_rdata = {r_irq_req, 26'd0, r_irq_id};
            default: w_rdata = w_tmr_rd;
        endcase
    end

    // Synchroniser, edge pending, in-service tracking and configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= {NIRQ{1'b0}};
            r_sync2   <= {NIRQ{1'b0}};
            r_dly     <= {NIRQ{1'b0}};
            r_ip_edge <= {NIRQ{1'b0}};
            r_mode    <= {NIRQ{1'b0}};
            r_ie      <= {NSRC{1'b0}};
            r_isr     <= {NSRC{1'b0}};
            r_gie     <= 1'b0;
        end else begin
            r_sync1   <= bus.irq_in;
            r_sync2   <= r_sync1;
            r_dly     <= r_sync2;
            r_ip_edge <= w_ip_edge_next;
            r_isr     <= w_isr_next;
            if (bus.cop0write) begin
                case (bus.cp0_writeaddress)
                    5'h00:   r_ie   <= bus.writecop0[NSRC-1:0];
                    5'h02:   r_mode <= bus.writecop0[NIRQ-1:0];
                    5'h03:   r_gie  <= bus.writecop0[0];
                    default: r_gie  <= r_gie;
                endcase
            end else begin
                r_gie <= r_gie;
            end
        end
    end

    // Count/Compare/TCTL per timer; a Count write overrides increment and reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NTIMERS; t++) begin
                r_count[t]   <= 32'd0;
                r_compare[t] <= 32'hFFFF_FFFF;
                r_tctl[t]    <= 2'b00;
            end
            r_ip_tmr <= {NTIMERS{1'b0}};
        end else begin
            r_ip_tmr <= w_ip_tmr_next;
            for (int t = 0; t < NTIMERS; t++) begin
                if (w_wr_cnt[t]) begin
                    r_count[t] <= bus.writecop0;
                end else if (w_hit[t] && r_tctl[t][1]) begin
                    r_count[t] <= 32'd0;
                end else if (r_tctl[t][0]) begin
                    r_count[t] <= r_count[t] + 32'd1;
                end else begin
                    r_count[t] <= r_count[t];
                end
                r_compare[t] <= w_wr_cmp[t]  ? bus.writecop0      : r_compare[t];
                r_tctl[t]    <= w_wr_tctl[t] ? bus.writecop0[1:0] : r_tctl[t];
            end
        end
    end

    // Registered request towards the exception unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_req <= 1'b0;
            r_irq_id  <= 5'd0;
        end else begin
            r_irq_req <= w_req;
            r_irq_id  <= w_top;
        end
    end

    assign bus.irq_req      = r_irq_req;
    assign bus.irq_id       = r_irq_id;
    assign bus.cop0readdata = w_rdata;
endmodule

// File: tb/tb_cp0_intc.sv
// Randomised self-checking bench for cp0_intc against a behavioural model of
// the register map, synchroniser latency, timers and nested arbitration.
module tb_cp0_intc;
    localparam int NIRQ    = 6;
    localparam int NTIMERS = 2;
    localparam int NSRC    = NIRQ + NTIMERS;

    logic clk = 1'b0;
    logic reset;
    cp0_intc_if #(.NIRQ(NIRQ)) bus ();
    cp0_intc #(.NIRQ(NIRQ), .NTIMERS(NTIMERS)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model state
    logic [31:0]     m_ie, m_mode, m_isr, m_ipe;
    logic            m_gie, m_req;
    logic [4:0]      m_id;
    logic [31:0]     m_cnt [NTIMERS];
    logic [31:0]     m_cmp [NTIMERS];
    logic            m_en  [NTIMERS];
    logic            m_per [NTIMERS];
    logic            m_ipt [NTIMERS];
    logic [NIRQ-1:0] h1, h2, h3;   // irq_in sampled 1, 2 and 3 edges ago
    logic [NIRQ-1:0] cur_irq;

    function automatic int hi(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p;
        p = 32'd0;
        for (int k = 0; k < NIRQ; k++) p[k] = m_mode[k] ? m_ipe[k] : h2[k];
        for (int t = 0; t < NTIMERS; t++) p[NIRQ + t] = m_ipt[t];
        return p;
    endfunction

    function automatic logic [31:0] mread(input int a);
        if (a == 0) return m_ie;
        if (a == 1) return m_pend();
        if (a == 2) return m_mode;
        if (a == 3) return {31'd0, m_gie};
        if (a == 4) return m_isr;
        if (a == 5) return {m_req, 26'd0, m_id};
        if (a >= 8 && a < 8 + 2 * NTIMERS) return (a % 2 == 1) ? m_cmp[(a - 8) / 2] : m_cnt[(a - 8) / 2];
        if (a >= 16 && a < 16 + NTIMERS) return {30'd0, m_per[a - 16], m_en[a - 16]};
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_ie = 32'd0; m_mode = 32'd0; m_isr = 32'd0; m_ipe = 32'd0;
        m_gie = 1'b0; m_req = 1'b0; m_id = 5'd0;
        h1 = '0; h2 = '0; h3 = '0;
        for (int t = 0; t < NTIMERS; t++) begin
            m_cnt[t] = 32'd0; m_cmp[t] = 32'hFFFF_FFFF;
            m_en[t] = 1'b0; m_per[t] = 1'b0; m_ipt[t] = 1'b0;
        end
    endtask

    // One clock edge of the model: everything is evaluated from pre-edge state.
    task automatic model_edge(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [NIRQ-1:0] irq, input logic ack, input logic er);
        logic [31:0] cand;
        int          top, cur;
        logic        take, hit;
        cand = m_pend() & m_ie;
        top  = hi(cand);
        cur  = hi(m_isr);
        take = ack && m_req;
        if (er && cur >= 0) m_isr[cur] = 1'b0;
        if (take) m_isr[m_id] = 1'b1;
        for (int k = 0; k < NIRQ; k++) begin
            if (!m_mode[k]) m_ipe[k] = 1'b0;
            else if (h2[k] && !h3[k]) m_ipe[k] = 1'b1;
            else if ((wr && wa == 5'd1 && wd[k]) || (take && int'(m_id) == k)) m_ipe[k] = 1'b0;
        end
        for (int t = 0; t < NTIMERS; t++) begin
            hit = m_en[t] && (m_cnt[t] == m_cmp[t]);
            if (wr && int'(wa) == 9 + 2 * t) m_ipt[t] = 1'b0;
            else if (hit) m_ipt[t] = 1'b1;
            else if (wr && wa == 5'd1 && wd[NIRQ + t]) m_ipt[t] = 1'b0;
            if (wr && int'(wa) == 8 + 2 * t) m_cnt[t] = wd;
            else if (m_en[t]) m_cnt[t] = (hit && m_per[t]) ? 32'd0 : m_cnt[t] + 32'd1;
            if (wr && int'(wa) == 9 + 2 * t) m_cmp[t] = wd;
            if (wr && int'(wa) == 16 + t) begin
                m_en[t] = wd[0]; m_per[t] = wd[1];
            end
        end
        m_req = m_gie && (cand != 32'd0) && (top > cur);
        m_id  = (top < 0) ? 5'd0 : 5'(top);
        if (wr && wa == 5'd0) m_ie   = wd & 32'((64'd1 << NSRC) - 64'd1);
        if (wr && wa == 5'd2) m_mode = wd & 32'((64'd1 << NIRQ) - 64'd1);
        if (wr && wa == 5'd3) m_gie  = wd[0];
        h3 = h2; h2 = h1; h1 = irq;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.cp0_readaddress = a;
        #1;
        d = bus.cop0readdata;
    endtask

    task automatic step(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [NIRQ-1:0] irq, input logic ack, input logic er);
        logic [31:0] d;
        int          a;
        bus.cop0write = wr; bus.cp0_writeaddress = wa; bus.writecop0 = wd;
        bus.irq_in = irq; bus.irq_ack = ack; bus.eret = er;
        @(posedge clk);
        model_edge(wr, wa, wd, irq, ack, er);
        #1;
        chk("irq_req", 32'(bus.irq_req), 32'(m_req));
        chk("irq_id", 32'(bus.irq_id), 32'(m_id));
        rd(5'h01, d); chk("IP", d, mread(1));
        rd(5'h04, d); chk("ISR", d, mread(4));
        a = $urandom_range(0, 31);
        rd(5'(a), d); chk($sformatf("reg%0d", a), d, mread(a));
    endtask

    task automatic wrreg(input logic [4:0] a, input logic [31:0] d);
        step(1'b1, a, d, cur_irq, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, cur_irq, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        int          t, guard;
        reset = 1'b1;
        bus.irq_in = '0; bus.cop0write = 1'b0; bus.cp0_writeaddress = 5'd0;
        bus.cp0_readaddress = 5'd0; bus.writecop0 = 32'd0; bus.irq_ack = 1'b0; bus.eret = 1'b0;
        cur_irq = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            rd(5'(a), d); chk($sformatf("rst_reg%0d", a), d, mread(a));
        end
        rd(5'h09, d); chk("rst_cmp0", d, 32'hFFFF_FFFF);
        chk("rst_req", 32'(bus.irq_req), 32'd0);
        idle(3);
        rd(5'h01, d); chk("no_hit_tctl0", d, 32'd0);

        // Edge line 0: request on the 4th edge, then ack
        wrreg(5'h00, 32'h01); wrreg(5'h02, 32'h01); wrreg(5'h03, 32'h01);
        cur_irq[0] = 1'b1; idle(2);
        cur_irq[0] = 1'b0; idle(1);
        chk("edge_3rd_req", 32'(bus.irq_req), 32'd0);
        idle(1);
        chk("edge_4th_req", 32'(bus.irq_req), 32'd1);
        chk("edge_4th_id", 32'(bus.irq_id), 32'd0);
        step(1'b0, 5'd0, 32'd0, cur_irq, 1'b1, 1'b0);
        idle(1);
        rd(5'h04, d); chk("ack_isr", d, 32'h01);
        rd(5'h01, d); chk("ack_ip0", d & 32'h01, 32'd0);
        chk("ack_req_drop", 32'(bus.irq_req), 32'd0);

        // Nesting on level line 3
        wrreg(5'h00, 32'h0B);
        cur_irq[3] = 1'b1; idle(3);
        chk("nest_req", 32'(bus.irq_req), 32'd1);
        chk("nest_id", 32'(bus.irq_id), 32'd3);
        step(1'b0, 5'd0, 32'd0, cur_irq, 1'b1, 1'b0);
        idle(1);
        rd(5'h04, d); chk("nest_isr9", d, 32'h09);
        cur_irq[3] = 1'b0;
        step(1'b0, 5'd0, 32'd0, cur_irq, 1'b0, 1'b1);
        rd(5'h04, d); chk("eret1_isr", d, 32'h01);
        step(1'b0, 5'd0, 32'd0, cur_irq, 1'b0, 1'b1);
        rd(5'h04, d); chk("eret2_isr", d, 32'h00);
        cur_irq[3] = 1'b1; idle(3);
        step(1'b0, 5'd0, 32'd0, cur_irq, 1'b1, 1'b0);
        cur_irq[3] = 1'b0; idle(2);
        rd(5'h04, d); chk("isr8", d, 32'h08);
        cur_irq[1] = 1'b1; idle(4);
        chk("lower_no_req", 32'(bus.irq_req), 32'd0);
        cur_irq[1] = 1'b0;
        step(1'b0, 5'd0, 32'd0, cur_irq, 1'b0, 1'b1);
        idle(3);

        // Timer 0 periodic
        wrreg(5'h00, 32'h40); wrreg(5'h09, 32'd5); wrreg(5'h08, 32'd0); wrreg(5'h10, 32'h3);
        idle(5);
        rd(5'h08, d); chk("tmr_cnt5", d, 32'd5);
        idle(1);
        rd(5'h08, d); chk("tmr_reload0", d, 32'd0);
        rd(5'h01, d); chk("tmr_ip6", d & 32'h40, 32'h40);
        idle(1);
        chk("tmr_req", 32'(bus.irq_req), 32'd1);
        chk("tmr_id", 32'(bus.irq_id), 32'd6);
        wrreg(5'h01, 32'h40);
        guard = 0;
        while (!(m_en[0] && m_cnt[0] == m_cmp[0]) && guard < 20) begin
            idle(1); guard++;
        end
        chk("tmr_hit_found", 32'(guard < 20), 32'd1);
        wrreg(5'h09, 32'd5);
        rd(5'h01, d); chk("cmp_wr_beats_hit", d & 32'h40, 32'd0);

        // One-shot wrap
        wrreg(5'h10, 32'h0); wrreg(5'h08, 32'hFFFF_FFFE); wrreg(5'h09, 32'd0); wrreg(5'h10, 32'h1);
        idle(2);
        rd(5'h08, d); chk("wrap_cnt0", d, 32'd0);
        idle(1);
        rd(5'h08, d); chk("wrap_cnt1", d, 32'd1);
        rd(5'h01, d); chk("wrap_ip6", d & 32'h40, 32'h40);

        // W1C against a simultaneous edge
        wrreg(5'h00, 32'h01); wrreg(5'h02, 32'h01);
        cur_irq[0] = 1'b1; idle(1);
        cur_irq[0] = 1'b0; idle(3);
        cur_irq[0] = 1'b1; idle(2);
        wrreg(5'h01, 32'h01);
        rd(5'h01, d); chk("w1c_vs_edge", d & 32'h01, 32'h01);

        // GIE off holds the request low
        wrreg(5'h03, 32'h0); idle(2);
        chk("gie0_req", 32'(bus.irq_req), 32'd0);
        rd(5'h01, d); chk("gie0_ip0", d & 32'h01, 32'h01);

        // Asynchronous reset mid-request
        wrreg(5'h03, 32'h1); idle(2);
        chk("pre_rst_req", 32'(bus.irq_req), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("async_rst_req", 32'(bus.irq_req), 32'd0);
        cur_irq = '0;
        bus.irq_in = '0; bus.cop0write = 1'b0; bus.irq_ack = 1'b0; bus.eret = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        rd(5'h09, d); chk("post_rst_cmp0", d, 32'hFFFF_FFFF);

        // Randomised phase
        for (int n = 0; n < 2500; n++) begin
            wr = ($urandom_range(0, 3) == 0);
            t  = $urandom_range(0, NTIMERS - 1);
            case ($urandom_range(0, 10))
                0:       begin wa = 5'd0; wd = $urandom(); end
                1:       begin wa = 5'd1; wd = $urandom(); end
                2:       begin wa = 5'd2; wd = $urandom(); end
                3:       begin wa = 5'd3; wd = {31'd0, ($urandom_range(0, 5) != 0)}; end
                4:       begin wa = 5'd4; wd = $urandom(); end
                5, 6:    begin
                             wa = 5'(8 + 2 * t);
                             wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4))
                                                             : 32'($urandom_range(0, 12));
                         end
                7, 8:    begin wa = 5'(9 + 2 * t); wd = 32'($urandom_range(0, 12)); end
                default: begin wa = 5'(16 + t); wd = 32'($urandom_range(0, 3)); end
            endcase
            for (int k = 0; k < NIRQ; k++) if ($urandom_range(0, 7) == 0) cur_irq[k] = ~cur_irq[k];
            step(wr, wa, wd, cur_irq, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cp0_intc.md
# cp0_intc

Parametrised interrupt and timer controller for coprocessor 0. It replaces the fixed 8-line, single-timer interrupt path with a configurable number of sources and timers. Each source has per-source enable, edge or level mode and nested in-service tracking. The block sits beside the CP0 register file: MTC0/MFC0 reach its registers through the CP0 write/read ports, and its `irq_req`/`irq_id` feed the exception unit in place of the raw interrupt vector.

## Interface

- `NIRQ`, default 6: number of external interrupt lines, 1..28.
- `NTIMERS`, default 2: number of Count/Compare timers, 1..4.
- Derived `NSRC = NIRQ + NTIMERS` (at most 32). Source index k < NIRQ is external line k. Source NIRQ+t is timer t.
- Priority: a higher index has higher priority.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `irq_in`  in  NIRQ  raw external interrupt lines, asynchronous to `clk`.
- `cop0write`  in  1  register write strobe.
- `cp0_writeaddress`  in  5  write register index.
- `cp0_readaddress`  in  5  read register index.
- `writecop0`  in  32  write data.
- `cop0readdata`  out  32  combinational read data.
- `irq_ack`  in  1  pulse when the core takes the interrupt exception.
- `eret`  in  1  pulse on return from exception.
- `irq_req`  out  1  registered interrupt request.
- `irq_id`  out  5  registered index of the requesting source.

## Operation

Register map (unmapped reads return 0; unmapped writes are ignored):
- 0x00 IE: per-source enable, bits [NSRC-1:0].
- 0x01 IP: pending bits. Reads return pending. Writing 1 clears edge-mode external bits and timer bits. Level-mode bits ignore writes.
- 0x02 MODE: per-external-line mode, 1 = edge, 0 = level.
- 0x03 CTRL: bit0 is GIE (global interrupt enable).
- 0x04 ISR: in-service bitmap, read-only.
- 0x05 VECTOR: read-only; bit31 = `irq_req`, [4:0] = `irq_id`.
- 0x08+2t Count t; 0x09+2t Compare t.
- 0x10+t TCTL t: bit0 = enable, bit1 = periodic.

External lines:
- Each line passes through a 2-flop synchroniser giving `s`, plus a delay flop `p`.
- Edge mode: a rising edge (`s & ~p`) sets pending on the next clock edge.
- Edge and clear in the same cycle (W1C write or ack): the set wins.
- Level mode: pending equals `s` directly, with no storage.

Timers:
- When enabled, Count increments every cycle and wraps from 0xFFFFFFFF to 0.
- Hit condition: enable & (Count == Compare).
- On a hit, pending is set. In periodic mode Count loads 0 on that edge instead of incrementing.
- A Count write overrides both increment and periodic reload.
- A Compare write clears that timer's pending bit. This clear beats a hit in the same cycle.
- A disabled timer holds Count and never hits.

Arbitration:
- `cand` = pending & IE.
- `top` = highest index set in `cand`.
- `cur` = highest index set in ISR, or -1 if ISR is empty.
- The request condition is GIE & (cand ≠ 0) & (top > cur).
- The register update is `irq_req <= request condition`, `irq_id <= top`.

Ack and eret:
- `irq_ack` while `irq_req` = 1:
  - sets ISR[`irq_id`];
  - clears pending[`irq_id`] only if that source is an edge-mode external line;
  - is ignored while `irq_req` = 0.
- `eret` clears the highest set ISR bit; with ISR empty it does nothing.
- When ack and eret occur in the same cycle, eret's clear uses the pre-ack ISR, then the ack's set is applied.
- GIE = 0 forces `irq_req` low. Pending bits still accumulate.

## Timing

- Reset values:
  - IE, IP storage, MODE, GIE, ISR, TCTL, Count, synchroniser and delay flops: 0.
  - Compare: 0xFFFFFFFF.
  - `irq_req`: 0; `irq_id`: 0.
- Register writes take effect on the `clk` edge where `cop0write` = 1.
- Reads are combinational and reflect state after the last edge.
- `irq_in` rising, edge mode, line enabled: `irq_req` rises on the 4th rising `clk` edge after the input change is first sampled. Level mode: on the 3rd edge.
- Timer: the hit occurs in the cycle with Count == Compare; pending is set at the end of that cycle, and `irq_req` follows one edge later.
- After an ack, `irq_req` is re-evaluated on the following edge using the updated ISR. It drops unless a strictly higher source is pending.
- Asserting `reset` mid-operation clears all state immediately. `irq_req` falls without waiting for a clock edge.

## Test plan

- Reset, then read all registers: Compare = 0xFFFFFFFF, every other register = 0, `irq_req` = 0; no timer hit with TCTL = 0.
- IE = 0x01, MODE = 0x01, GIE = 1; pulse `irq_in[0]`: `irq_req` = 1 and `irq_id` = 0 after 4 edges. Ack: IP[0] clears, ISR = 0x01, `irq_req` = 0 on the next edge.
- Nesting:
  - Source 0 is in service.
  - Raising level line 3 (IE bit 3 set) gives `irq_req` with `irq_id` = 3. Ack gives ISR = 0x09.
  - The first eret gives ISR = 0x01; the second gives ISR = 0x00.
  - Raising line 1 while ISR = 0x08 gives no request.
- Timer 0, periodic:
  - Setup: Compare0 = 5, TCTL0 = 0x3, IE bit 6 set (NIRQ = 6).
  - Required: Count runs 0..5 then 0, IP[6] sets, `irq_id` = 6.
  - Writing Compare0 in the hit cycle leaves IP[6] = 0.
- Count0 = 0xFFFFFFFE, Compare0 = 0, one-shot mode: Count wraps to 0, the hit occurs, and Count continues to 1.
- Simultaneous events: W1C of IP[0] in the same cycle as a new edge leaves IP[0] = 1. GIE = 0 with a pending source holds `irq_req` = 0. Asserting `reset` mid-request drops `irq_req` immediately.
